// File: rtl/rv32m_pkg.sv
// Shared encodings and combinational helpers for the RV32M multiply/divide unit.
package rv32m_pkg;

   localparam int XLEN_C = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [XLEN_C-1:0] DIV0_Q = 32'hFFFF_FFFF;
   localparam logic [XLEN_C-1:0] OVF_Q  = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic [XLEN_C-1:0] magnitude(input logic [XLEN_C-1:0] v, input logic sgn);
      return (sgn && v[XLEN_C-1]) ? -v : v;
   endfunction

   // A zero divisor must not flip the all-ones quotient, so DIV only negates when b != 0.
   function automatic logic result_neg(input logic [2:0] f3,
                                       input logic [XLEN_C-1:0] a,
                                       input logic [XLEN_C-1:0] b);
      logic neg;
      neg = 1'b0;
      case (f3)
         F3_MULH:   neg = a[XLEN_C-1] ^ b[XLEN_C-1];
         F3_MULHSU: neg = a[XLEN_C-1];
         F3_DIV:    neg = (a[XLEN_C-1] ^ b[XLEN_C-1]) && (b != '0);
         F3_REM:    neg = a[XLEN_C-1];
         default:   neg = 1'b0;
      endcase
      return neg;
   endfunction

   function automatic logic [XLEN_C-1:0] fix_result(input logic [2:0] f3,
                                                    input logic [2*XLEN_C-1:0] acc,
                                                    input logic neg);
      logic [2*XLEN_C-1:0] prod;
      logic [XLEN_C-1:0]   quo;
      logic [XLEN_C-1:0]   rem;
      logic [XLEN_C-1:0]   res;
      prod = neg ? -acc : acc;
      quo  = neg ? -acc[XLEN_C-1:0] : acc[XLEN_C-1:0];
      rem  = neg ? -acc[2*XLEN_C-1:XLEN_C] : acc[2*XLEN_C-1:XLEN_C];
      case (f3)
         F3_MUL:                        res = prod[XLEN_C-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  res = prod[2*XLEN_C-1:XLEN_C];
         F3_DIV, F3_DIVU:               res = quo;
         default:                       res = rem;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M execution unit: radix-2 shift-add multiply and restoring divide
// sharing one 64-bit working register, feeding a single register-file write port.
module rv32m_muldiv
   import rv32m_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);

   state_e            state_q, state_d;
   logic [4:0]        cnt_q;
   logic              setup_q;

   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [XLEN-1:0]   d_q;
   logic              neg_q;
   logic [2*XLEN-1:0] acc_q;

   logic              accept;
   logic              is_div;
   logic              div0, ovf, special;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN-1:0]   special_res;
   logic [XLEN:0]     mul_sum, div_diff;
   logic [2*XLEN-1:0] acc_step;

   assign accept = (state_q == IDLE) && start && !kill;
   assign is_div = f3_q[2];
   assign mag_a  = magnitude(a_q, a_is_signed(f3_q));
   assign mag_b  = magnitude(b_q, b_is_signed(f3_q));

   // Signed-overflow case exists only for DIV/REM (funct3[0] clear among divides).
   assign div0    = (b_q == '0);
   assign ovf     = !f3_q[0] && (a_q == OVF_Q) && (b_q == DIV0_Q);
   assign special = EARLY_OUT && is_div && (div0 || ovf);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      special_res = '0;
      if (div0)
         special_res = f3_q[1] ? a_q : DIV0_Q;
      else if (!f3_q[1])
         special_res = OVF_Q;
   end

   // One iteration: multiply adds the multiplicand into the high half and shifts right;
   // divide shifts left and keeps the trial subtraction when it does not borrow.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
      div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, d_q};
      if (is_div)
         acc_step = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = CALC;
         CALC: begin
            if (kill)
               state_d = IDLE;
            else if (setup_q)
               state_d = special ? DONE : CALC;
            else if (cnt_q == 5'd31)
               state_d = FIX;
         end
         FIX:     state_d = kill ? IDLE : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign wb_we = done && (wb_rd != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         setup_q <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= '0;
            setup_q <= 1'b1;
         end else if (state_q == CALC) begin
            setup_q <= 1'b0;
            if (!setup_q && !kill)
               cnt_q <= cnt_q + 5'd1;
         end
         if (state_q == CALC && setup_q && special && !kill) begin
            wb_rd   <= rd_q;
            wb_data <= special_res;
         end else if (state_q == FIX && !kill) begin
            wb_rd   <= rd_q;
            wb_data <= fix_result(f3_q, acc_q, neg_q);
         end
      end
   end

   // NOTE: datapath registers carry no reset; each is loaded before any output depends on it.
   always_ff @(posedge clk) begin
      if (accept) begin
         f3_q <= funct3;
         rd_q <= rd;
         a_q  <= op_a;
         b_q  <= op_b;
      end
      if (state_q == CALC) begin
         if (setup_q) begin
            neg_q <= result_neg(f3_q, a_q, b_q);
            d_q   <= is_div ? mag_b : mag_a;
            acc_q <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
         end else begin
            acc_q <= acc_step;
         end
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench: two instances (early-out on/off) share stimulus; per-instance
// scoreboards hold expected write-backs and the cycle at which DONE must appear.
module tb_rv32m_muldiv;
   import rv32m_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, kill;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd;

   logic        busy1, done1, we1;
   logic [4:0]  rd1;
   logic [31:0] data1;
   logic        busy0, done0, we0;
   logic [4:0]  rd0;
   logic [31:0] data0;

   rv32m_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut_eo (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .rd(rd), .kill(kill), .busy(busy1), .done(done1), .wb_we(we1), .wb_rd(rd1), .wb_data(data1));

   rv32m_muldiv #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_it (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .rd(rd), .kill(kill), .busy(busy0), .done(done0), .wb_we(we0), .wb_rd(rd0), .wb_data(data0));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];
   logic [31:0] last1 = '0;
   logic [31:0] last0 = '0;

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 32'd0) ||
             ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      r  = '0;
      case (f3)
         F3_MUL:    begin p = {32'd0, a} * {32'd0, b}; r = p[31:0];  end
         F3_MULH:   begin p = sa * sb;                 r = p[63:32]; end
         F3_MULHSU: begin p = sa * ub;                 r = p[63:32]; end
         F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
         F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                        32'($signed(a) / $signed(b));
         F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    r = (b == 0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                        32'($signed(a) % $signed(b));
         default:   r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Each DONE cycle pops one expectation; a DONE with nothing queued is itself a failure.
   always @(negedge clk) begin : mon_eo
      exp_t e;
      if (rst_n && done1) begin
         if (q1.size() == 0) check("eo unexpected done", 32'(done1), 32'd0);
         else begin
            e = q1.pop_front();
            check("eo wb_rd", 32'(rd1), 32'(e.rd));
            check("eo wb_data", data1, e.data);
            check("eo wb_we", 32'(we1), 32'(e.rd != 5'd0));
            check("eo done cycle", cyc, e.due);
            last1 = e.data;
         end
      end
      if (rst_n && we1 && !done1) check("eo we without done", 32'(we1), 32'd0);
   end

   always @(negedge clk) begin : mon_it
      exp_t e;
      if (rst_n && done0) begin
         if (q0.size() == 0) check("it unexpected done", 32'(done0), 32'd0);
         else begin
            e = q0.pop_front();
            check("it wb_rd", 32'(rd0), 32'(e.rd));
            check("it wb_data", data0, e.data);
            check("it wb_we", 32'(we0), 32'(e.rd != 5'd0));
            check("it done cycle", cyc, e.due);
            last0 = e.data;
         end
      end
      if (rst_n && we0 && !done0) check("it we without done", 32'(we0), 32'd0);
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] expv, input bit push);
      @(posedge clk);
      #1;
      funct3 = f3; op_a = a; op_b = b; rd = r; start = 1'b1;
      if (push) begin
         q1.push_back('{rd: r, data: expv, due: cyc + (is_special(f3, a, b) ? 2 : 35)});
         q0.push_back('{rd: r, data: expv, due: cyc + 35});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (!busy1 && !busy0 && q1.size() == 0 && q0.size() == 0) return;
      end
      check("idle timeout pending", 32'(q1.size() + q0.size()), 32'd0);
      check("idle timeout busy", {30'd0, busy1, busy0}, 32'd0);
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{F3_MULH,   32'd7,          32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFFF};
      vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
      vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF};
      vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
      vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
      vecs[6]  = '{F3_DIVU,   32'h8000_0000,  32'd3,         5'd11, 32'h2AAA_AAAA};
      vecs[7]  = '{F3_REMU,   32'h8000_0000,  32'd3,         5'd12, 32'h0000_0002};
      vecs[8]  = '{F3_DIV,    32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF};
      vecs[9]  = '{F3_REMU,   32'd5,          32'd0,         5'd14, 32'd5};
      vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000};
      vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0};
      vecs[12] = '{F3_DIV,    32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFF};
      vecs[13] = '{F3_REM,    32'hFFFF_FFFB,  32'd0,         5'd18, 32'hFFFF_FFFB};
      vecs[14] = '{F3_MUL,    32'd3,          32'd4,         5'd0,  32'd12};
      vecs[15] = '{F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000};
      vecs[16] = '{F3_DIVU,   32'd7,          32'hFFFF_FFFF, 5'd20, 32'd0};
      vecs[17] = '{F3_REM,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFF};

      rst_n = 1'b0; start = 1'b0; kill = 1'b0;
      funct3 = '0; op_a = '0; op_b = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy",    {30'd0, busy1, busy0}, 32'd0);
      check("reset done",    {30'd0, done1, done0}, 32'd0);
      check("reset wb_we",   {30'd0, we1, we0},     32'd0);
      check("reset wb_rd",   {22'd0, rd1, rd0},     32'd0);
      check("reset wb_data", data1 | data0,         32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
         wait_idle(100);
      end

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 4 == 3) ? 32'd0 : $urandom;
         issue(f3, a, b, 5'(i + 1), model(f3, a, b), 1'b1);
         wait_idle(100);
      end

      // Start re-pulsed while busy must be dropped, not queued.
      issue(F3_MUL, 32'd1000, 32'd1000, 5'd3, 32'd1_000_000, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      funct3 = F3_DIVU; op_a = 32'd99; op_b = 32'd9; rd = 5'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(100);

      // Kill mid-CALC: no write-back, previous result held, next start accepted.
      issue(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22, 32'd0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill busy",    {30'd0, busy1, busy0}, 32'd0);
      check("kill wb_we",   {30'd0, we1, we0},     32'd0);
      check("kill eo data", data1, last1);
      check("kill it data", data0, last0);
      issue(F3_DIV, 32'd100, 32'hFFFF_FFF6, 5'd23, 32'hFFFF_FFF6, 1'b1);
      wait_idle(100);

      // Asynchronous reset in the middle of CALC.
      issue(F3_MUL, 32'd9, 32'd9, 5'd24, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst busy",    {30'd0, busy1, busy0}, 32'd0);
      check("async rst done",    {30'd0, done1, done0}, 32'd0);
      check("async rst wb_we",   {30'd0, we1, we0},     32'd0);
      check("async rst wb_rd",   {22'd0, rd1, rd0},     32'd0);
      check("async rst wb_data", data1 | data0,         32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(F3_DIVU, 32'd10, 32'd3, 5'd25, 32'd3, 1'b1);
      wait_idle(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
